// File: rtl/mem_access_unit_pkg.sv
// Shared widths, FSM encodings and bus helpers for the MEM-stage access engine.
package mem_access_unit_pkg;

  localparam int DATA_BUS    = 32;
  localparam int ADDR_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;
  localparam int TO_CNT_W    = 8;

  localparam logic [1:0] MEM_ST_IDLE = 2'd0;
  localparam logic [1:0] MEM_ST_BUSY = 2'd1;
  localparam logic [1:0] MEM_ST_DONE = 2'd2;

  localparam logic [MEM_SEL_BUS-1:0] SEL_NONE = 4'b0000;
  localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] SEL_WORD = 4'b1111;

  function automatic logic [MEM_SEL_BUS-1:0] write_strobes(
    input logic [MEM_SEL_BUS-1:0] sel,
    input logic [1:0]             lane
  );
    return sel << lane;
  endfunction

  // Byte stores drive the same byte on every lane; the strobes pick the target.
  function automatic logic [DATA_BUS-1:0] store_lanes(
    input logic [MEM_SEL_BUS-1:0] sel,
    input logic [DATA_BUS-1:0]    data
  );
    return (sel == SEL_BYTE) ? {4{data[7:0]}} : data;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load formatter: lane select plus sign/zero extension of the captured word.
module mem_access_unit_load_extract
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_BUS-1:0]    i_word,
  input  logic [1:0]             i_lane,
  input  logic [MEM_SEL_BUS-1:0] i_sel,
  input  logic                   i_sign_ext,
  output logic [DATA_BUS-1:0]    o_result
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  always_comb begin
    o_result = i_word;
    if (i_sel == SEL_BYTE) begin
      o_result = {{24{i_sign_ext & w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine with registered ready-handshaked RAM bus.
// Optional misaligned-word trap compiled in with MEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass addr_in straight through
// BUSY  | bus request out, waiting for ram_ready or the timeout
// DONE  | result presented for one cycle, pipeline released
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mem_read_flag,
  input  logic                   i_mem_write_flag,
  input  logic                   i_mem_sign_ext_flag,
  input  logic [MEM_SEL_BUS-1:0] i_mem_sel,
  input  logic [DATA_WIDTH-1:0]  i_mem_write_data,
  input  logic [DATA_WIDTH-1:0]  i_addr_in,
  input  logic                   i_ram_ready,
  input  logic [DATA_WIDTH-1:0]  i_ram_read_data,
  output logic                   o_ram_en,
  output logic [MEM_SEL_BUS-1:0] o_ram_write_en,
  output logic [DATA_WIDTH-1:0]  o_ram_addr,
  output logic [DATA_WIDTH-1:0]  o_ram_write_data,
  output logic [DATA_WIDTH-1:0]  o_result_out,
  output logic                   o_stall_request,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                   o_align_error,
`endif
  output logic                   o_bus_error
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]             r_state;
  logic                   r_ram_en;
  logic [MEM_SEL_BUS-1:0] r_ram_write_en;
  logic [DATA_WIDTH-1:0]  r_ram_addr;
  logic [DATA_WIDTH-1:0]  r_ram_write_data;
  logic [DATA_WIDTH-1:0]  r_load;
  logic [TO_CNT_W-1:0]    r_to_cnt;
  logic                   r_bus_error;

  logic                   w_access;
  logic                   w_misalign;
  logic                   w_issue;
  logic                   w_timeout;
  logic [1:0]             w_lane;
  logic [DATA_WIDTH-1:0]  w_load_ext;
  logic [DATA_WIDTH-1:0]  w_result;

  assign w_access = i_mem_read_flag | i_mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign    = w_access && (i_mem_sel == SEL_WORD) && (i_addr_in[1:0] != 2'b00);
  assign o_align_error = (r_state == MEM_ST_IDLE) && w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = (r_state == MEM_ST_IDLE) && w_access && !w_misalign;
  assign w_timeout = (r_state == MEM_ST_BUSY) && !i_ram_ready && (r_to_cnt == TO_LAST);

  // Word accesses ignore the low address bits (forced alignment).
  assign w_lane = (i_mem_sel == SEL_WORD) ? 2'b00 : i_addr_in[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= MEM_ST_IDLE;
      r_ram_en         <= 1'b0;
      r_ram_write_en   <= SEL_NONE;
      r_ram_addr       <= '0;
      r_ram_write_data <= '0;
      r_load           <= '0;
      r_to_cnt         <= '0;
      r_bus_error      <= 1'b0;
    end else begin
      case (r_state)
        MEM_ST_IDLE: begin
          if (w_issue) begin
            r_state          <= MEM_ST_BUSY;
            r_ram_en         <= 1'b1;
            r_ram_addr       <= {i_addr_in[DATA_WIDTH-1:2], 2'b00};
            r_ram_write_en   <= i_mem_write_flag ? write_strobes(i_mem_sel, w_lane) : SEL_NONE;
            r_ram_write_data <= store_lanes(i_mem_sel, i_mem_write_data);
            r_to_cnt         <= '0;
          end
        end
        MEM_ST_BUSY: begin
          r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
          if (i_ram_ready) begin
            r_load         <= i_ram_read_data;
            r_ram_en       <= 1'b0;
            r_ram_write_en <= SEL_NONE;
            r_state        <= MEM_ST_DONE;
          end else if (w_timeout) begin
            r_load         <= '0;
            r_ram_en       <= 1'b0;
            r_ram_write_en <= SEL_NONE;
            r_bus_error    <= 1'b1;
            r_state        <= MEM_ST_DONE;
          end
        end
        MEM_ST_DONE: begin
          // The instruction is still on the inputs here; it must not re-issue.
          r_state     <= MEM_ST_IDLE;
          r_bus_error <= 1'b0;
        end
        default: begin
          r_state     <= MEM_ST_IDLE;
          r_bus_error <= 1'b0;
        end
      endcase
    end
  end

  mem_access_unit_load_extract u_load_extract (
    .i_word     (r_load),
    .i_lane     (w_lane),
    .i_sel      (i_mem_sel),
    .i_sign_ext (i_mem_sign_ext_flag),
    .o_result   (w_load_ext)
  );

  always_comb begin
    w_result = i_addr_in;
    if ((r_state == MEM_ST_IDLE) && w_misalign) begin
      w_result = '0;
    end else if ((r_state == MEM_ST_DONE) && i_mem_read_flag) begin
      w_result = w_load_ext;
    end
  end

  assign o_result_out     = w_result;
  assign o_stall_request  = w_issue || (r_state == MEM_ST_BUSY);
  assign o_ram_en         = r_ram_en;
  assign o_ram_write_en   = r_ram_write_en;
  assign o_ram_addr       = r_ram_addr;
  assign o_ram_write_data = r_ram_write_data;
  assign o_bus_error      = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; expected results queued at issue, compared at DONE.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sx;
  logic [3:0]  sel;
  logic [31:0] wdata, addr, rdata_bus;
  logic        ready;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wd, result;
  logic        stall, berr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .DATA_WIDTH(32)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_mem_read_flag     (rd),
    .i_mem_write_flag    (wr),
    .i_mem_sign_ext_flag (sx),
    .i_mem_sel           (sel),
    .i_mem_write_data    (wdata),
    .i_addr_in           (addr),
    .i_ram_ready         (ready),
    .i_ram_read_data     (rdata_bus),
    .o_ram_en            (ram_en),
    .o_ram_write_en      (ram_we),
    .o_ram_addr          (ram_addr),
    .o_ram_write_data    (ram_wd),
    .o_result_out        (result),
    .o_stall_request     (stall),
`ifdef MEM_ALIGN_CHECK_EN
    .o_align_error       (align_err),
`endif
    .o_bus_error         (berr)
  );

  typedef struct {
    logic [31:0] result;
    int          stall;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    int          berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // observations from the last run_access
  int          obs_stall, obs_berr_cnt;
  logic [31:0] obs_result, obs_addr_b, obs_wd_b, obs_result_after;
  logic [3:0]  obs_we_b, obs_we_done;
  logic        obs_en_b, obs_en_done, obs_en_after, obs_stall_after, obs_expired;

  function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] a, logic [3:0] s, logic e);
    logic [31:0] sh;
    logic [7:0]  b;
    if (s == 4'b1111) return w;
    sh = w >> (8 * a[1:0]);
    b  = sh[7:0];
    return (e && b[7]) ? {24'hFF_FFFF, b} : {24'h0, b};
  endfunction

  function automatic logic [3:0] model_we(logic w, logic [3:0] s, logic [31:0] a);
    if (!w) return 4'b0000;
    if (s == 4'b1111) return 4'b1111;
    if (s != 4'b0001) return 4'b0000;
    case (a[1:0])
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic push_exp(logic r, logic w, logic e, logic [3:0] s, logic [31:0] d,
                          logic [31:0] a, logic [31:0] word, int waits, logic tmo);
    exp_t x;
    x.result = (r && tmo) ? 32'h0 : (r ? model_load(word, a, s, e) : a);
    x.stall  = tmo ? TO + 1 : waits + 2;
    x.addr   = {a[31:2], 2'b00};
    x.we     = model_we(w, s, a);
    x.wd     = (s == 4'b0001) ? {4{d[7:0]}} : d;
    x.berr   = tmo ? 1 : 0;
    sb_q.push_back(x);
  endtask

  // Drives one instruction and records what the DUT did; checks live in the scenario tasks.
  task automatic run_access(logic r, logic w, logic e, logic [3:0] s, logic [31:0] d,
                            logic [31:0] a, logic [31:0] word, int waits);
    int  n;
    logic done;
    n = 0; done = 1'b0;
    obs_berr_cnt = 0; obs_expired = 1'b0;
    obs_en_b = 1'b0; obs_we_b = 4'h0; obs_addr_b = 32'h0; obs_wd_b = 32'h0;
    @(posedge clk); #1;
    rd = r; wr = w; sx = e; sel = s; wdata = d; addr = a; ready = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done        = 1'b1;
        obs_result  = result;
        obs_en_done = ram_en;
        obs_we_done = ram_we;
        if (berr) obs_berr_cnt++;
      end else begin
        n++;
        if (berr) obs_berr_cnt++;
        if (n == 2) begin
          obs_en_b = ram_en; obs_we_b = ram_we; obs_addr_b = ram_addr; obs_wd_b = ram_wd;
        end
        ready     = (n == waits + 2);
        rdata_bus = ready ? word : 32'hDEAD_BEEF;
      end
    end
    obs_stall   = n;
    obs_expired = !done;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; sx = 1'b0; sel = 4'b0000; ready = 1'b0;
    @(negedge clk);
    obs_stall_after  = stall;
    obs_en_after     = ram_en;
    obs_result_after = result;
    if (berr) obs_berr_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 0; wr = 0; sx = 0; sel = 4'h0; wdata = 32'h0; addr = 32'h55;
    ready = 1'b0; rdata_bus = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
    n_cmp++; if (ram_we !== 4'h0) begin n_bad++; $display("FAIL reset_ram_we: got %b want 0000", ram_we); end
    n_cmp++; if (ram_addr !== 32'h0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_cmp++; if (ram_wd !== 32'h0) begin n_bad++; $display("FAIL reset_ram_wd: got %h want 0", ram_wd); end
    n_cmp++; if (berr !== 1'b0) begin n_bad++; $display("FAIL reset_bus_error: got %b want 0", berr); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (result !== 32'h55) begin n_bad++; $display("FAIL reset_result: got %h want 00000055", result); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [31:0] tbl[3] = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h8000_0003};
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      addr = tbl[i]; ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (result !== tbl[i]) begin n_bad++; $display("FAIL pass_result[%0d]: got %h want %h", i, result, tbl[i]); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pass_stall[%0d]: got %b want 0", i, stall); end
      @(negedge clk);
      n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL pass_ram_en[%0d]: got %b want 0", i, ram_en); end
    end
    @(posedge clk); #1; ready = 1'b0;
  endtask

  typedef struct {
    logic r, w, e;
    logic [3:0]  s;
    logic [31:0] d, a, word;
    int          waits;
  } acc_t;

  task automatic test_loads();
    acc_t t[$];
    exp_t x;
    t.push_back('{1, 0, 1, 4'b0001, 32'h0, 32'h0000_0100, 32'h0000_0080, 0});
    t.push_back('{1, 0, 0, 4'b0001, 32'h0, 32'h0000_010A, 32'h12F4_5678, 1});
    t.push_back('{1, 0, 1, 4'b0001, 32'h0, 32'h0000_010B, 32'h7F00_0000, 2});
    t.push_back('{1, 0, 1, 4'b0001, 32'h0, 32'h0000_0109, 32'h0000_9C00, 0});
    t.push_back('{1, 0, 0, 4'b1111, 32'h0, 32'h0000_0404, 32'h89AB_CDEF, 2});
    t.push_back('{1, 0, 0, 4'b1111, 32'h0, 32'h0000_0500, 32'h1357_9BDF, TO - 1});
`ifndef MEM_ALIGN_CHECK_EN
    t.push_back('{1, 0, 1, 4'b1111, 32'h0, 32'h0000_0406, 32'hF0E1_D2C3, 1});
`endif
    foreach (t[i]) begin
      push_exp(t[i].r, t[i].w, t[i].e, t[i].s, t[i].d, t[i].a, t[i].word, t[i].waits, 1'b0);
      run_access(t[i].r, t[i].w, t[i].e, t[i].s, t[i].d, t[i].a, t[i].word, t[i].waits);
      x = sb_q.pop_front();
      n_cmp++; if (obs_expired !== 1'b0) begin n_bad++; $display("FAIL load_budget[%0d]: stall never released", i); end
      n_cmp++; if (obs_result !== x.result) begin n_bad++; $display("FAIL load_result[%0d]: got %h want %h", i, obs_result, x.result); end
      n_cmp++; if (obs_stall !== x.stall) begin n_bad++; $display("FAIL load_stall[%0d]: got %0d want %0d", i, obs_stall, x.stall); end
      n_cmp++; if (obs_en_b !== 1'b1 || obs_addr_b !== x.addr) begin n_bad++; $display("FAIL load_bus[%0d]: en %b addr %h want 1 %h", i, obs_en_b, obs_addr_b, x.addr); end
      n_cmp++; if (obs_we_b !== x.we) begin n_bad++; $display("FAIL load_we[%0d]: got %b want %b", i, obs_we_b, x.we); end
      n_cmp++; if (obs_en_done !== 1'b0 || obs_berr_cnt != x.berr) begin n_bad++; $display("FAIL load_done[%0d]: en %b berr_cnt %0d want 0 %0d", i, obs_en_done, obs_berr_cnt, x.berr); end
      n_cmp++; if (obs_stall_after !== 1'b0 || obs_en_after !== 1'b0) begin n_bad++; $display("FAIL load_retrigger[%0d]: stall %b en %b want 0 0", i, obs_stall_after, obs_en_after); end
    end
  endtask

  task automatic test_stores();
    acc_t t[$];
    exp_t x;
    t.push_back('{0, 1, 0, 4'b0001, 32'h1234_56AB, 32'h0000_0203, 32'h0, 3});
    t.push_back('{0, 1, 0, 4'b0001, 32'h0000_0011, 32'h0000_0200, 32'h0, 0});
    t.push_back('{0, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0204, 32'h0, 0});
`ifndef MEM_ALIGN_CHECK_EN
    t.push_back('{0, 1, 0, 4'b1111, 32'hA5A5_0F0F, 32'h0000_040A, 32'h0, 1});
`endif
    foreach (t[i]) begin
      push_exp(t[i].r, t[i].w, t[i].e, t[i].s, t[i].d, t[i].a, t[i].word, t[i].waits, 1'b0);
      run_access(t[i].r, t[i].w, t[i].e, t[i].s, t[i].d, t[i].a, t[i].word, t[i].waits);
      x = sb_q.pop_front();
      n_cmp++; if (obs_expired !== 1'b0) begin n_bad++; $display("FAIL store_budget[%0d]: stall never released", i); end
      n_cmp++; if (obs_result !== x.result) begin n_bad++; $display("FAIL store_result[%0d]: got %h want %h", i, obs_result, x.result); end
      n_cmp++; if (obs_stall !== x.stall) begin n_bad++; $display("FAIL store_stall[%0d]: got %0d want %0d", i, obs_stall, x.stall); end
      n_cmp++; if (obs_addr_b !== x.addr || obs_en_b !== 1'b1) begin n_bad++; $display("FAIL store_addr[%0d]: got %h en %b want %h 1", i, obs_addr_b, obs_en_b, x.addr); end
      n_cmp++; if (obs_we_b !== x.we) begin n_bad++; $display("FAIL store_we[%0d]: got %b want %b", i, obs_we_b, x.we); end
      n_cmp++; if (obs_wd_b !== x.wd) begin n_bad++; $display("FAIL store_wd[%0d]: got %h want %h", i, obs_wd_b, x.wd); end
      n_cmp++; if (obs_we_done !== 4'h0 || obs_en_done !== 1'b0) begin n_bad++; $display("FAIL store_done_bus[%0d]: en %b we %b want 0 0000", i, obs_en_done, obs_we_done); end
      n_cmp++; if (obs_result_after !== x.result) begin n_bad++; $display("FAIL store_after[%0d]: got %h want %h", i, obs_result_after, x.result); end
    end
  endtask

  task automatic test_timeout();
    exp_t x;
    push_exp(1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0000_0600, 32'hFFFF_FFFF, 1000, 1'b1);
    run_access(1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0000_0600, 32'hFFFF_FFFF, 1000);
    x = sb_q.pop_front();
    n_cmp++; if (obs_expired !== 1'b0) begin n_bad++; $display("FAIL timeout_budget: stall never released"); end
    n_cmp++; if (obs_stall !== x.stall) begin n_bad++; $display("FAIL timeout_stall: got %0d want %0d", obs_stall, x.stall); end
    n_cmp++; if (obs_result !== x.result) begin n_bad++; $display("FAIL timeout_result: got %h want %h", obs_result, x.result); end
    n_cmp++; if (obs_berr_cnt != x.berr) begin n_bad++; $display("FAIL timeout_berr_pulses: got %0d want %0d", obs_berr_cnt, x.berr); end
    n_cmp++; if (obs_en_done !== 1'b0) begin n_bad++; $display("FAIL timeout_ram_en: got %b want 0", obs_en_done); end
    n_cmp++; if (obs_stall_after !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: stall %b want 0", obs_stall_after); end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    @(posedge clk); #1;
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_0700; ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ram_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_en: got %b want 1", ram_en); end
    rst = 1'b1; rd = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
    n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram_en: got %b want 0", ram_en); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    rst = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0704, 32'h2468_ACE0, 1, 1'b0);
    run_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0000_0704, 32'h2468_ACE0, 1);
    x = sb_q.pop_front();
    n_cmp++; if (obs_result !== x.result) begin n_bad++; $display("FAIL rstmid_lw_result: got %h want %h", obs_result, x.result); end
    n_cmp++; if (obs_stall !== x.stall) begin n_bad++; $display("FAIL rstmid_lw_stall: got %0d want %0d", obs_stall, x.stall); end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    @(posedge clk); #1;
    wr = 1'b1; sel = 4'b1111; wdata = 32'h1111_2222; addr = 32'h0000_0302;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (align_err !== 1'b1) begin n_bad++; $display("FAIL align_flag[%0d]: got %b want 1", c, align_err); end
      n_cmp++; if (stall !== 1'b0 || result !== 32'h0) begin n_bad++; $display("FAIL align_stall_result[%0d]: stall %b result %h want 0 0", c, stall, result); end
      n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL align_ram_en[%0d]: got %b want 0", c, ram_en); end
    end
    sel = 4'b0001; addr = 32'h0000_0303;
    #1;
    n_cmp++; if (align_err !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL align_byte: align %b stall %b want 0 1", align_err, stall); end
    wr = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_timeout();
    test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
